prm_load_ctrl: RTL and testbench
================================

Name: prm_load_ctrl

Overview:
- Sequences parameter (weight/bias) loading from the input AXI-stream into the F_NUM tiny_dnn_core instances.
- Generates per-beat core select (prm_v), weight address (prm_a) and write strobe, and owns src_ready during load modes.
- Checks stream framing against configured filter count and kernel size; reports done/error to the batch level.
- Sits between the host-side stream and the core write ports, in parallel with batch_ctrl (which it relieves of parameter addressing).

Parameters:
F_NUM, 16, number of cores (filters) that can be loaded.
VW, 4, width of core select; F_NUM <= 2**VW.
AW, 10, width of weight address.

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
wwrite  in  1  weight-load mode level
bwrite  in  1  bias-load mode level
od  in  VW  number of filters to load minus 1 (0..F_NUM-1), sampled at start
ks  in  AW  weights per filter minus 1, sampled at start
src_valid  in  1  stream beat valid
src_last  in  1  stream last beat marker
src_ready  out  1  stream ready
prm_we  out  1  write strobe to selected core (src_valid & src_ready)
prm_v  out  VW  selected core index
prm_a  out  AW  weight address within core (0 in bias mode)
prm_bias  out  1  current load is bias (core bwrite)
busy  out  1  load in progress
done  out  1  one-cycle pulse on correct completion
err  out  1  sticky framing error, cleared at next start

Behaviour:
- Reset (rst_n low, async): state IDLE; prm_v=0, prm_a=0, prm_bias=0, busy=0, done=0, err=0, src_ready=0, armed=0, od/ks shadow regs=0.
- States: IDLE, LOAD, DONE, WAIT_REL.
- IDLE: start when (wwrite|bwrite)=1 and armed=0 (rising-edge arm). If both high, wwrite wins (weight load, prm_bias=0); bwrite alone -> prm_bias=1. On start: latch od, ks; prm_v=0, prm_a=0, err=0, armed=1, busy=1 -> LOAD next cycle. src_ready stays 0 in IDLE.
- LOAD: src_ready=1 (decoded from registered state, no combinational path from src_valid). prm_we = src_valid & src_ready. Beat accepted when prm_we=1; prm_v/prm_a show the address of the current beat (zero-latency, write happens the same cycle).
- Weight mode advance on accepted beat: if prm_a==ks_l, prm_a<=0 and prm_v<=prm_v+1; else prm_a<=prm_a+1.
- Bias mode advance: prm_a held 0; prm_v<=prm_v+1 every beat.
- Final beat = (prm_v==od_l) & (bias mode | prm_a==ks_l). Final beat with src_last=1 -> DONE. Final beat with src_last=0 -> err<=1, -> DONE (excess beats stay with upstream; src_ready drops).
- Non-final beat with src_last=1 -> err<=1, early termination -> DONE.
- src_valid=0 in LOAD: hold all counters; no timeout.
- DONE: done=1 for exactly this cycle, src_ready=0, busy<=0 -> WAIT_REL.
- WAIT_REL/IDLE: armed cleared when wwrite=0 and bwrite=0 at clk edge; WAIT_REL -> IDLE. No restart while mode level remains high.
- Mode drop mid-LOAD (wwrite=0 & bwrite=0): abort -> IDLE same edge, no done, err unchanged, busy=0, counters reset to 0, armed=0. Beat coinciding with abort cycle is still written (src_ready registered high that cycle).
- Mode switch mid-LOAD (e.g. wwrite->bwrite with no low gap) ignored; load completes in latched mode.
- Counters never wrap beyond od_l: final-beat detection is the only exit; od_l=0, ks_l=0 means single-beat load.
- prm_bias valid throughout LOAD; held until next start.

Test Plan:
- Weight load od=1, ks=3, 8 back-to-back beats, last on beat 8 -> prm_we 8 cycles, (prm_v,prm_a) = (0,0..3),(1,0..3); done pulse 1 cycle after beat 8; err=0.
- Bias load od=15, src_valid toggling 1/0, 16 beats with last on 16th -> prm_a=0 always, prm_v 0..15, prm_bias=1, done once, src_ready=0 after.
- Early last: weight od=0, ks=9, src_last on beat 4 -> 4 writes (a=0..3), err=1, done pulse, src_ready=0; next start clears err.
- Missing last: od=0, ks=2, 3 beats src_last=0 -> err=1, done; extra valid beat not accepted (src_ready=0).
- Abort: od=3, ks=9, wwrite drops after 5 beats -> no done, busy=0, prm_v=prm_a=0; re-raise wwrite -> fresh load from (0,0).
- Async reset asserted mid-LOAD between edges -> all outputs 0 immediately; wwrite held high through reset release -> new start only after armed=0 from reset, load begins next edge.

Source files
------------

// File: rtl/prm_load_ctrl.sv
// prm_load_ctrl: steps weight/bias beats from the parameter stream into the core write ports.
// Write strobe is zero-latency (valid & ready); ready comes only from registered LOAD state.
module prm_load_ctrl #(
  parameter int F_NUM = 16,
  parameter int VW    = 4,
  parameter int AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wwrite,
  input  logic          i_bwrite,
  input  logic [VW-1:0] i_od,
  input  logic [AW-1:0] i_ks,
  input  logic          i_src_valid,
  input  logic          i_src_last,
  output logic          o_src_ready,
  output logic          o_prm_we,
  output logic [VW-1:0] o_prm_v,
  output logic [AW-1:0] o_prm_a,
  output logic          o_prm_bias,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  if (F_NUM > (1 << VW)) begin : g_cfg_chk
    $error("prm_load_ctrl: F_NUM does not fit in VW bits");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_WAIT_REL} state_t;

  state_t        r_state;
  logic          r_armed;
  logic [VW-1:0] r_od_l;
  logic [AW-1:0] r_ks_l;
  logic [VW-1:0] r_prm_v;
  logic [AW-1:0] r_prm_a;
  logic          r_bias;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic w_mode;
  logic w_src_ready;
  logic w_we;
  logic w_a_end;
  logic w_final;

  assign w_mode      = i_wwrite | i_bwrite;
  assign w_src_ready = (r_state == S_LOAD);
  assign w_we        = i_src_valid & w_src_ready;
  assign w_a_end     = (r_prm_a == r_ks_l);
  assign w_final     = (r_prm_v == r_od_l) & (r_bias | w_a_end);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_armed <= 1'b0;
      r_od_l  <= '0;
      r_ks_l  <= '0;
      r_prm_v <= '0;
      r_prm_a <= '0;
      r_bias  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mode && !r_armed) begin
            r_state <= S_LOAD;
            r_od_l  <= i_od;
            r_ks_l  <= i_ks;
            r_bias  <= ~i_wwrite;
            r_prm_v <= '0;
            r_prm_a <= '0;
            r_err   <= 1'b0;
            r_armed <= 1'b1;
            r_busy  <= 1'b1;
          end else if (!w_mode) begin
            r_armed <= 1'b0;
          end
        end
        S_LOAD: begin
          // Abort takes priority; a beat presented this cycle is still written.
          if (!w_mode) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_prm_v <= '0;
            r_prm_a <= '0;
            r_armed <= 1'b0;
          end else if (w_we) begin
            if (w_final || i_src_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= w_final ^ i_src_last;
            end else if (r_bias || w_a_end) begin
              r_prm_v <= r_prm_v + 1'b1;
              r_prm_a <= '0;
            end else begin
              r_prm_a <= r_prm_a + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_WAIT_REL;
        end
        default: begin
          if (!w_mode) begin
            r_armed <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign o_src_ready = w_src_ready;
  assign o_prm_we    = w_we;
  assign o_prm_v     = r_prm_v;
  assign o_prm_a     = r_prm_a;
  assign o_prm_bias  = r_bias;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_prm_load_ctrl.sv
// Scoreboard bench for prm_load_ctrl: expected beat addresses and completions are queued at issue.
module tb_prm_load_ctrl;

  localparam int VW = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wwrite, bwrite;
  logic [VW-1:0] od;
  logic [AW-1:0] ks;
  logic          src_valid, src_last;
  logic          src_ready, prm_we, prm_bias, busy, done, err;
  logic [VW-1:0] prm_v;
  logic [AW-1:0] prm_a;

  prm_load_ctrl #(.F_NUM(16), .VW(VW), .AW(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wwrite(wwrite), .i_bwrite(bwrite),
    .i_od(od), .i_ks(ks), .i_src_valid(src_valid), .i_src_last(src_last),
    .o_src_ready(src_ready), .o_prm_we(prm_we), .o_prm_v(prm_v), .o_prm_a(prm_a),
    .o_prm_bias(prm_bias), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bias;
    int v;
    int a;
  } wr_t;

  wr_t exp_w[$];
  int  exp_d[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every strobe / done pulse is matched against the queues.
  wr_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (prm_we === 1'b1) begin
        if (exp_w.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: v=%0d a=%0d, none expected", prm_v, prm_a);
        end else begin
          e = exp_w.pop_front();
          check("write_v", int'(prm_v), e.v);
          check("write_a", int'(prm_a), e.a);
          check("write_bias", int'(prm_bias), e.bias);
        end
      end
      if (done === 1'b1) begin
        if (exp_d.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: err=%0d, no completion expected", err);
        end else begin
          check("done_err", int'(err), exp_d.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d failed of %0d", n_fail, n_tests);
    $fatal(1, "timeout");
  end

  // Beat i of a load lands on core i/(ks+1), word i%(ks+1); bias loads use one word per core.
  task automatic push_writes(input int bias, input int k, input int n);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      w.bias = bias;
      w.v    = bias ? i : i / (k + 1);
      w.a    = bias ? 0 : i % (k + 1);
      exp_w.push_back(w);
    end
  endtask

  task automatic push_load(input int bias, input int o, input int k, input int last_idx,
                           output int n_acc, output int exp_err);
    int total;
    total   = (o + 1) * (bias ? 1 : k + 1);
    n_acc   = (last_idx < total) ? last_idx + 1 : total;
    exp_err = (last_idx == total - 1) ? 0 : 1;
    push_writes(bias, k, n_acc);
    exp_d.push_back(exp_err);
  endtask

  task automatic start_load(input int bias, input int both, input int o, input int k);
    od     = VW'(o);
    ks     = AW'(k);
    wwrite = (!bias) || both;
    bwrite = bias || both;
    @(posedge clk); #1;
    check("start_busy", int'(busy), 1);
    check("start_ready", int'(src_ready), 1);
    check("start_err_clr", int'(err), 0);
  endtask

  // gaps: 0 back-to-back, 1 strict valid toggling, 2 random idles
  task automatic drive_beats(input int n, input int last_idx, input int gaps, input int sw_at);
    for (int i = 0; i < n; i++) begin
      int idle;
      idle = (gaps == 1) ? ((i > 0) ? 1 : 0) : (gaps == 2) ? $urandom_range(0, 2) : 0;
      src_valid = 1'b0;
      src_last  = 1'b0;
      repeat (idle) begin
        @(posedge clk); #1;
      end
      if (i == sw_at) begin
        wwrite = 1'b0;
        bwrite = 1'b1;
      end
      src_valid = 1'b1;
      src_last  = (i == last_idx);
      @(posedge clk); #1;
    end
    src_valid = 1'b0;
    src_last  = 1'b0;
  endtask

  task automatic finish_load(input int exp_err);
    check("post_ready", int'(src_ready), 0);
    @(posedge clk); #1;
    check("post_busy", int'(busy), 0);
    check("post_done", int'(done), 0);
    wwrite = 1'b0;
    bwrite = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sticky_err", int'(err), exp_err);
  endtask

  task automatic full_load(input int bias, input int both, input int o, input int k,
                           input int last_idx, input int gaps, input int sw_at);
    int n_acc, exp_err, extra;
    push_load(bias && !both, o, k, last_idx, n_acc, exp_err);
    extra = (last_idx >= n_acc) ? 1 : 0;
    start_load(bias, both, o, k);
    drive_beats(n_acc + extra, last_idx, gaps, sw_at);
    finish_load(exp_err);
  endtask

  initial begin
    rst_n = 1'b0; wwrite = 1'b0; bwrite = 1'b0; od = '0; ks = '0;
    src_valid = 1'b0; src_last = 1'b0;
    #7;
    check("rst_ready", int'(src_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_v", int'(prm_v), 0);
    check("rst_a", int'(prm_a), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    full_load(0, 0, 1, 3, 7, 0, -1);     // weights 2x4 back-to-back
    full_load(1, 0, 15, 0, 15, 1, -1);   // 16 biases, valid toggling
    full_load(0, 0, 0, 9, 3, 0, -1);     // early last
    full_load(0, 0, 0, 2, 99, 0, -1);    // missing last, extra beat refused
    full_load(0, 0, 0, 0, 0, 0, -1);     // single-beat load
    full_load(1, 1, 1, 2, 5, 0, -1);     // both levels high: weight wins
    full_load(0, 0, 1, 2, 5, 2, 2);      // mode switch mid-load ignored

    // Abort: wwrite drops together with the 5th beat, which is still written.
    push_writes(0, 9, 5);
    start_load(0, 0, 3, 9);
    drive_beats(4, 99, 0, -1);
    src_valid = 1'b1;
    wwrite    = 1'b0;
    @(posedge clk); #1;
    src_valid = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_v", int'(prm_v), 0);
    check("abort_a", int'(prm_a), 0);
    check("abort_ready", int'(src_ready), 0);
    check("abort_err", int'(err), 0);
    @(posedge clk); #1;
    full_load(0, 0, 1, 1, 3, 0, -1);

    // Async reset mid-load, wwrite held high across release.
    push_writes(0, 3, 3);
    start_load(0, 0, 2, 3);
    drive_beats(3, 99, 0, -1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", int'(src_ready), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_v", int'(prm_v), 0);
    check("arst_a", int'(prm_a), 0);
    check("arst_bias", int'(prm_bias), 0);
    check("arst_we", int'(prm_we), 0);
    @(posedge clk); #1;
    check("arst_hold_busy", int'(busy), 0);
    begin
      int n_acc, exp_err;
      push_load(0, 1, 1, 3, n_acc, exp_err);
      od = VW'(1);
      ks = AW'(1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rel_busy", int'(busy), 1);
      check("rel_ready", int'(src_ready), 1);
      drive_beats(n_acc, 3, 0, -1);
      finish_load(exp_err);
    end

    // Randomised loads against the arithmetic model.
    for (int t = 0; t < 20; t++) begin
      int bias, o, k, total, kind, li;
      bias  = $urandom_range(0, 1);
      o     = $urandom_range(0, 3);
      k     = $urandom_range(0, 4);
      total = (o + 1) * (bias ? 1 : k + 1);
      kind  = $urandom_range(0, 3);
      if (kind == 2 && total > 1) li = $urandom_range(0, total - 2);
      else if (kind == 3)         li = total;
      else                        li = total - 1;
      full_load(bias, 0, o, k, li, 2, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("exp_writes_drained", exp_w.size(), 0);
    check("exp_done_drained", exp_d.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
